// File: rtl/mlp_hidden_ctrl.sv
// Hidden-layer controller: owns the weight/bias bank, sequences one inference at a time
// and captures the datapath scores. Optional ReLU at capture: define MLP_HCTRL_RELU_EN.
module mlp_hidden_ctrl #(
  parameter int W   = 8,
  parameter int N   = 8,
  parameter int LAT = 1,
  parameter int AW  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [W-1:0]         cfg_wdata,
  output logic                 cfg_ready,
  output logic                 cfg_err,
  input  logic                 in_valid,
  input  logic [15:0]          in_x,
  output logic                 in_ready,
  output logic [15:0]          dp_x,
  output logic [N*16*W-1:0]    w_h_bus,
  output logic [N*W-1:0]       b_h_bus,
  input  logic [N*(W+5)-1:0]   dp_h_raw,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*(W+5)-1:0]   out_h,
  output logic                 busy
);

  localparam int HW = W + 5;
  localparam int NW = N * 16;
  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CW-1:0]       count_r;
  logic [NW*W-1:0]     w_bank_r;
  logic [N*W-1:0]      b_bank_r;
  logic [15:0]         dp_x_r;
  logic [N*HW-1:0]     out_h_r;
  logic                out_valid_r;
  logic                cfg_err_r;
  logic                cfg_wr_s;
  logic                accept_s;
  logic                capture_s;
  logic                release_s;
  logic                addr_bad_s;

  // Score shaping applied at capture; negative fields clamp to zero when ReLU is built in.
  function automatic logic [N*HW-1:0] shape_scores(input logic [N*HW-1:0] raw);
    logic [N*HW-1:0] res;
    res = raw;
`ifdef MLP_HCTRL_RELU_EN
    for (int k = 0; k < N; k++) begin
      if (raw[k*HW + HW - 1]) begin
        res[k*HW +: HW] = {HW{1'b0}};
      end else begin
        res[k*HW +: HW] = raw[k*HW +: HW];
      end
    end
`endif
    return res;
  endfunction

  assign addr_bad_s = (cfg_addr >= AW'(N * 17));

  // Next-state and handshake strobes; a config write wins over an input on the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    cfg_wr_s    = 1'b0;
    accept_s    = 1'b0;
    capture_s   = 1'b0;
    release_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cfg_we) begin
          cfg_wr_s = 1'b1;
        end else if (in_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (count_r == CW'(0)) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (out_valid_r && out_ready) begin
          release_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Weight/bias bank; out-of-range addresses leave it untouched and flag a one-cycle error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_bank_r  <= {(NW*W){1'b0}};
      b_bank_r  <= {(N*W){1'b0}};
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= cfg_wr_s && addr_bad_s;
      if (cfg_wr_s) begin
        for (int i = 0; i < NW; i++) begin
          if (cfg_addr == AW'(i)) begin
            w_bank_r[i*W +: W] <= cfg_wdata;
          end
        end
        for (int k = 0; k < N; k++) begin
          if (cfg_addr == AW'(NW + k)) begin
            b_bank_r[k*W +: W] <= cfg_wdata;
          end
        end
      end
    end
  end

  // Input hold, latency counter and result capture/handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_x_r      <= 16'h0000;
      count_r     <= CW'(0);
      out_h_r     <= {(N*HW){1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      if (accept_s) begin
        dp_x_r  <= in_x;
        count_r <= CW'(LAT);
      end else if (state_r == ST_WAIT && count_r != CW'(0)) begin
        count_r <= count_r - CW'(1);
      end
      if (capture_s) begin
        out_h_r     <= shape_scores(dp_h_raw);
        out_valid_r <= 1'b1;
      end else if (release_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign cfg_ready = (state_r == ST_IDLE);
  assign in_ready  = (state_r == ST_IDLE) && !cfg_we;
  assign busy      = (state_r != ST_IDLE);
  assign cfg_err   = cfg_err_r;
  assign dp_x      = dp_x_r;
  assign w_h_bus   = w_bank_r;
  assign b_h_bus   = b_bank_r;
  assign out_h     = out_h_r;
  assign out_valid = out_valid_r;

endmodule

// File: doc/mlp_hidden_ctrl.md
Name: mlp_hidden_ctrl

Overview:
Controller for the hidden-layer score datapath. It owns the weight/bias bank and drives the flattened weight and bias buses from registers loaded over a serial config port. It sequences one inference at a time: it accepts a 16-bit input with valid/ready, holds it on the datapath, waits out the datapath latency, then captures the hidden raw scores and presents them with valid/ready to the downstream output layer.

Parameters:
W, 8, weight/bias width (signed)
N, 8, hidden neurons
LAT, 1, datapath register latency in cycles (>=1)
AW, 8, config address width; must satisfy 2^AW >= N*17

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  config write strobe
cfg_addr  in  AW  0..N*16-1 = weight (neuron*16+input); N*16..N*17-1 = bias of neuron (addr-N*16)
cfg_wdata  in  W  signed value to write
cfg_ready  out  1  writes accepted (IDLE only)
cfg_err  out  1  one-cycle pulse: accepted write with out-of-range address
in_valid  in  1  input vector valid
in_x  in  16  input bits
in_ready  out  1  input accepted this cycle
dp_x  out  16  to datapath x
w_h_bus  out  N*16*W  to datapath weights
b_h_bus  out  N*W  to datapath biases
dp_h_raw  in  N*(W+5)  from datapath hidden raw scores
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_h  out  N*(W+5)  captured scores, neuron k at [k*(W+5) +: W+5]
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; weight/bias bank, dp_x, out_h, counter = 0; out_valid=0; cfg_err=0. Reset mid-operation drops any transaction in flight; no output is produced for it.
- States: IDLE, WAIT, HOLD.
- cfg_ready = (state==IDLE). in_ready = (state==IDLE) && !cfg_we. Config write has priority over input on the same cycle.
- IDLE, cfg_we=1: write cfg_wdata at cfg_addr on the edge; an address >= N*17 leaves the bank unchanged and sets cfg_err=1 for the next cycle only. cfg_we outside IDLE is ignored with no error.
- IDLE, in_valid && in_ready: dp_x <= in_x; counter <= LAT; go to WAIT.
- WAIT: counter != 0 -> decrement. counter == 0 -> out_h <= dp_h_raw, out_valid <= 1, go to HOLD. The capture edge is accept edge + LAT + 1.
- HOLD: out_h and dp_x are stable. out_valid && out_ready -> out_valid <= 0, go to IDLE. The next input can be accepted on the following edge.
- The bank, dp_x and out_h change only on the edges defined above. w_h_bus and b_h_bus are direct register outputs.
- Throughput: one inference per LAT+3 cycles minimum.

Optional Feature:
MLP_HCTRL_RELU_EN
- Defined: at capture, each neuron field of dp_h_raw that is negative is stored as 0 in out_h (ReLU). Non-negative fields pass unchanged.
- Undefined: out_h is the raw signed capture.
- Timing and handshakes are identical either way.

Test Plan:
- Load all 128 weights = 1 and all biases = 0, then send in_x=16'hFFFF with out_ready=1 -> out_valid 2 cycles after accept (LAT=1); every field = +16.
- Same bank, in_x=16'h0000 -> every field = -16 (13'h1FF0). With MLP_HCTRL_RELU_EN -> every field = 0.
- Neuron 0: bias = 8'h80, weights = 8'h7F; in_x=16'hFFFF -> field 0 = 1904. Other neurons unchanged.
- Hold out_ready=0 for 5 cycles in HOLD, pulsing in_valid and cfg_we -> out_h stable, in_ready=0, cfg_ready=0, bank unchanged. Then raise out_ready -> IDLE the next cycle.
- In IDLE, assert cfg_we (addr 5) and in_valid together -> write happens, in_ready=0. The input is accepted the next cycle.
- Write to addr 136 (N=8) -> cfg_err high exactly one cycle, bank unchanged. Assert rst in WAIT -> out_valid stays 0, state IDLE, bank cleared.
